pfd_lock_detect: RTL and testbench
==================================

PFD_LOCK_DETECT -- requirements
Module: pfd_lock_detect

Interface
REQ-001 Parameter ERR_W, default 8: width of signed phase-error output.
REQ-002 Parameter LOCK_TOL, default 2: max |phase error| in clk cycles counted as a good comparison.
REQ-003 Parameter LOCK_COUNT, default 16: consecutive good comparisons required to declare lock.
REQ-004 Parameter TIMEOUT, default 1024: clk cycles without a completed comparison before lock is dropped.
REQ-005 clk  input  1  sampling clock, all state updates on posedge; must be much faster than ref_in.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ref_in  input  1  reference clock, asynchronous to clk.
REQ-008 fb_in  input  1  feedback clock from the divider out port, asynchronous to clk.
REQ-009 up  output  1  high while reference leads feedback.
REQ-010 down  output  1  high while feedback leads reference.
REQ-011 phase_err  output  ERR_W  signed cycle count of last comparison; positive = reference leads.
REQ-012 err_valid  output  1  one-cycle pulse when phase_err updates.
REQ-013 locked  output  1  lock indicator.

Function
REQ-014 Each of ref_in, fb_in SHALL pass a 2-flop synchronizer then a rising-edge detector; rise pulse is one clk wide, 3 clk cycles after the input rise is first sampled.
REQ-015 FSM states IDLE, UP, DOWN; IDLE after reset.
REQ-016 IDLE: ref rise only -> UP; fb rise only -> DOWN; both in same cycle -> stay IDLE, complete comparison with error 0.
REQ-017 UP: fb rise -> IDLE, complete comparison with error +count; ref rise without fb rise -> stay UP, count continues.
REQ-018 DOWN: ref rise -> IDLE, complete comparison with error -count; fb rise without ref rise -> stay DOWN, count continues.
REQ-019 UP or DOWN with both rises in the same cycle -> IDLE, complete comparison with +count (UP) or -count (DOWN).
REQ-020 Cycle counter SHALL clear on entering UP/DOWN to 1, increment each cycle in UP/DOWN, saturate at 2^(ERR_W-1)-1.
REQ-021 up, down SHALL be registered decodes of state (up = state UP, down = state DOWN); never both high.
REQ-022 On comparison complete, phase_err SHALL load the signed error and err_valid SHALL pulse high the next cycle; otherwise err_valid low and phase_err holds.
REQ-023 Good comparison: |error| <= LOCK_TOL; good-run counter increments (saturating at LOCK_COUNT); bad comparison clears it to 0.
REQ-024 locked SHALL assert the cycle after the good-run counter reaches LOCK_COUNT and deassert the cycle after any bad comparison.
REQ-025 Timeout counter SHALL clear on every completed comparison; on reaching TIMEOUT it SHALL clear locked and the good-run counter and hold at TIMEOUT until the next comparison.

Reset
REQ-026 rst high SHALL immediately force: state IDLE, up 0, down 0, phase_err 0, err_valid 0, locked 0, all counters and synchronizer/edge flops 0.
REQ-027 Reset mid-comparison SHALL discard the comparison with no err_valid pulse; after release, the first rise starts a fresh comparison.

Structure
REQ-028 FSM state encodings (IDLE=2'd0, UP=2'd1, DOWN=2'd2) and default parameter values SHALL live in the shared pll_defs package/header.
REQ-029 Synchronizer plus edge detector SHALL be one sub-module, edge_sync (ports clk, rst, d, rise), instantiated for ref_in and fb_in.

Verification (ERR_W=8, LOCK_TOL=2, LOCK_COUNT=4, TIMEOUT=64)
REQ-030 ref and fb rise in the same clk cycle, period 20 clk, 5 periods -> err_valid x5, phase_err 0, up/down never high, locked high after 4th err_valid.
REQ-031 ref leads fb by 5 clk -> up high 5 cycles per period, phase_err +5, locked stays 0.
REQ-032 fb leads ref by 7 clk after lock -> down high 7 cycles, phase_err -7, locked drops the cycle after err_valid.
REQ-033 ref rises 3 times with fb held low -> up stays high, counter saturates at +127, then one fb rise -> phase_err +127.
REQ-034 Locked, then both inputs stopped -> locked falls 64 cycles after last completed comparison.
REQ-035 rst pulsed while in UP -> up 0 immediately, no err_valid, next aligned edges restart counting from 0 good comparisons.

Source files
------------

// File: rtl/pfd_lock_detect_pkg.sv
// Shared PLL definitions: FSM encodings and default parameters for the
// phase/frequency detector and lock detector.
package pll_defs;

  localparam int ERR_W_DEF      = 8;
  localparam int LOCK_TOL_DEF   = 2;
  localparam int LOCK_COUNT_DEF = 16;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } pfd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The rise pulse is one clk wide.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_rise;

  // Synchronize d, remember last synchronized level, flag 0->1 transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], d};
      r_prev <= r_sync[1];
      r_rise <= r_sync[1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/pfd_lock_detect.sv
// Sampled phase/frequency detector with signed phase-error measurement and
// lock detection (consecutive good comparisons, dropped on inactivity).
module pfd_lock_detect
  import pll_defs::*;
#(
  parameter int ERR_W      = ERR_W_DEF,
  parameter int LOCK_TOL   = LOCK_TOL_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    down,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ERR_W-1:0] CNT_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0] TOL      = ERR_W'(LOCK_TOL);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [TW-1:0]    TO_MAX   = TW'(TIMEOUT);

  logic                    w_ref_rise, w_fb_rise;
  pfd_state_t              r_state, w_next;
  logic                    w_done, w_start, w_good, w_timeout;
  logic signed [ERR_W-1:0] w_err;
  logic [ERR_W-1:0]        w_mag;
  logic [ERR_W-1:0]        r_cnt;
  logic [GW-1:0]           r_good;
  logic [TW-1:0]           r_to;
  logic                    r_up, r_down, r_err_valid, r_locked;
  logic signed [ERR_W-1:0] r_phase_err;

  edge_sync u_ref_sync (.clk(clk), .rst(rst), .d(ref_in), .rise(w_ref_rise));
  edge_sync u_fb_sync  (.clk(clk), .rst(rst), .d(fb_in),  .rise(w_fb_rise));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state, comparison-complete strobe and signed error
  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_start = 1'b0;
    w_err   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_done = 1'b1;
        end else if (w_ref_rise) begin
          w_next  = ST_UP;
          w_start = 1'b1;
        end else if (w_fb_rise) begin
          w_next  = ST_DOWN;
          w_start = 1'b1;
        end
      end
      ST_UP: begin
        if (w_fb_rise) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_err  = $signed(r_cnt);
        end
      end
      ST_DOWN: begin
        if (w_ref_rise) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_err  = -$signed(r_cnt);
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_mag     = w_err[ERR_W-1] ? ERR_W'(-w_err) : ERR_W'(w_err);
  assign w_good    = (w_mag <= TOL);
  assign w_timeout = (r_to == TO_MAX);

  // Phase counter: starts at 1 on entering UP/DOWN, saturates at max positive
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_cnt <= '0;
    else if (w_start)                               r_cnt <= ERR_W'(1);
    else if (r_state != ST_IDLE && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  // Registered outputs: up/down decoded from next state so they track state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_phase_err <= '0;
      r_err_valid <= 1'b0;
    end else begin
      r_up        <= (w_next == ST_UP);
      r_down      <= (w_next == ST_DOWN);
      r_err_valid <= w_done;
      if (w_done) r_phase_err <= w_err;
    end
  end

  // Good-run and inactivity counters; lock follows a full good run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good   <= '0;
      r_to     <= '0;
      r_locked <= 1'b0;
    end else begin
      if (w_done) begin
        r_to <= '0;
        if (!w_good)               r_good <= '0;
        else if (r_good != GOOD_MAX) r_good <= r_good + 1'b1;
      end else if (w_timeout) begin
        r_good <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
      r_locked <= (r_good == GOOD_MAX) && !w_timeout;
    end
  end

  assign up        = r_up;
  assign down      = r_down;
  assign phase_err = r_phase_err;
  assign err_valid = r_err_valid;
  assign locked    = r_locked;

endmodule

// File: tb/tb_pfd_lock_detect.sv
// Scoreboard bench for pfd_lock_detect: stimulus pushes expected phase
// errors and up/down pulse lengths; a negedge monitor pops and compares.
module tb_pfd_lock_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_in = 1'b0;
  logic fb_in = 1'b0;
  logic up, down, err_valid, locked;
  logic signed [7:0] phase_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_ev = 0;
  int up_run = 0;
  int dn_run = 0;
  bit both_hi = 1'b0;
  int exp_err[$];
  int exp_up[$];
  int exp_dn[$];

  pfd_lock_detect #(
    .ERR_W(8), .LOCK_TOL(2), .LOCK_COUNT(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .down(down), .phase_err(phase_err),
    .err_valid(err_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      up_run = 0;
      dn_run = 0;
    end else begin
      if (up && down) both_hi = 1'b1;
      if (up) up_run++;
      else if (up_run > 0) begin
        if (exp_up.size() == 0) chk("up_unexpected", up_run, 0);
        else chk("up_len", up_run, exp_up.pop_front());
        up_run = 0;
      end
      if (down) dn_run++;
      else if (dn_run > 0) begin
        if (exp_dn.size() == 0) chk("down_unexpected", dn_run, 0);
        else chk("down_len", dn_run, exp_dn.pop_front());
        dn_run = 0;
      end
      if (err_valid) begin
        last_ev = cyc;
        if (exp_err.size() == 0) chk("err_valid_unexpected", 1, 0);
        else chk("phase_err", phase_err, exp_err.pop_front());
      end
    end
  end

  // One 20-cycle period; lead>0 means ref rises lead cycles before fb
  task automatic run_period(input int lead, input int n);
    int ro, fo;
    ro = (lead < 0) ? -lead : 0;
    fo = (lead > 0) ? lead : 0;
    for (int p = 0; p < n; p++) begin
      exp_err.push_back(lead);
      if (lead > 0) exp_up.push_back(lead);
      if (lead < 0) exp_dn.push_back(-lead);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        ref_in = (k >= ro) && (k < ro + 3);
        fb_in  = (k >= fo) && (k < fo + 3);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    chk("rst_phase_err", phase_err, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;

    // aligned edges: lock after the 4th good comparison
    run_period(0, 3);
    chk("lock_after_3", locked, 0);
    run_period(0, 2);
    chk("lock_after_5", locked, 1);

    // ref leads by 5: bad comparisons, lock drops and stays low
    run_period(5, 1);
    chk("lock_drop_up5", locked, 0);
    run_period(5, 1);
    chk("lock_stay_up5", locked, 0);

    // relock, then fb leads by 7
    run_period(0, 4);
    chk("relock", locked, 1);
    run_period(-7, 1);
    chk("lock_drop_dn7", locked, 0);

    // ref rises 3x with fb low; counter saturates at +127
    exp_up.push_back(200);
    exp_err.push_back(127);
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      ref_in = (k < 60) && ((k % 20) < 3);
      fb_in  = (k >= 200) && (k < 203);
    end

    // lock then stop both inputs: timeout drops lock
    run_period(0, 4);
    chk("lock_before_timeout", locked, 1);
    while (cyc < last_ev + 60) @(negedge clk);
    chk("lock_pre_timeout", locked, 1);
    while (cyc < last_ev + 70) @(negedge clk);
    chk("lock_post_timeout", locked, 0);

    // reset while in UP: comparison discarded, good run restarts from 0
    run_period(0, 4);
    chk("lock_before_rst", locked, 1);
    @(negedge clk);
    ref_in = 1'b1;
    repeat (3) @(negedge clk);
    ref_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("up_before_rst", up, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_up", up, 0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_err_valid", err_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_period(0, 3);
    chk("after_rst_3good", locked, 0);
    run_period(0, 1);
    chk("after_rst_4good", locked, 1);

    // drain and final checks
    repeat (50) @(negedge clk);
    chk("err_queue_empty", exp_err.size(), 0);
    chk("up_queue_empty", exp_up.size(), 0);
    chk("dn_queue_empty", exp_dn.size(), 0);
    chk("up_down_exclusive", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
